mem_burst_responder: RTL and testbench

- Burst memory responder: the target end of the cache-to-memory read/write interface that the D-cache and I-cache drive.
- Accepts read requests and returns `len+1` data beats with `last`.
- Accepts write requests, then consumes `len+1` strobed data beats into an internal word array.
- Serves one transaction at a time. Used as the memory model behind the caches in block-level benches and as on-chip scratch memory.

---
 rtl/mem_burst_responder.sv | 140 ++++++++++++++
 tb/tb_mem_burst_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - single-transaction burst read/write memory responder
// Serves one read or write burst at a time from a 2^ADDR_W x 32-bit word array.
module mem_burst_responder #(
   parameter int ADDR_W     = 10,
   parameter int RD_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req_valid,
   input  logic [31:0] rd_req_addr,
   input  logic [7:0]  rd_req_len,
   output logic        rd_req_ready,
   output logic        rd_rsp_valid,
   output logic [31:0] rd_rsp_data,
   output logic        rd_rsp_last,
   input  logic        rd_rsp_ready,
   input  logic        wr_req_valid,
   input  logic [31:0] wr_req_addr,
   input  logic [7:0]  wr_req_len,
   output logic        wr_req_ready,
   input  logic        wr_data_valid,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_data_strb,
   input  logic        wr_data_last,
   output logic        wr_data_ready,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_BURST, S_WR_DATA} state_e;

   // RD_WAIT lasts RD_LATENCY cycles, so the counter is preloaded one short.
   localparam logic [3:0] LAT_INIT = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        lat_q, lat_d;
   logic              err_q, err_d;
   logic [31:0]       mem_q [2**ADDR_W];

   logic        rd_req_ready_c, wr_req_ready_c, rd_rsp_valid_c, rd_rsp_last_c, wr_data_ready_c;
   logic [31:0] rd_rsp_data_c;
   logic        wr_hs;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{rd_req_addr[31:ADDR_W+2], rd_req_addr[1:0],
                               wr_req_addr[31:ADDR_W+2], wr_req_addr[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; writes already committed stay committed.
   always_ff @(posedge clk) begin
      if (rst && wr_hs) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_data_strb[i]) mem_q[ptr_q][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      cnt_d           = cnt_q;
      lat_d           = lat_q;
      err_d           = err_q;
      rd_req_ready_c  = 1'b0;
      wr_req_ready_c  = 1'b0;
      rd_rsp_valid_c  = 1'b0;
      rd_rsp_last_c   = 1'b0;
      rd_rsp_data_c   = '0;
      wr_data_ready_c = 1'b0;
      wr_hs           = 1'b0;
      case (state_q)
         S_IDLE: begin
            wr_req_ready_c = 1'b1;
            rd_req_ready_c = !wr_req_valid;
            if (wr_req_valid) begin
               ptr_d   = wr_req_addr[ADDR_W+1:2];
               cnt_d   = wr_req_len;
               state_d = S_WR_DATA;
            end else if (rd_req_valid) begin
               ptr_d   = rd_req_addr[ADDR_W+1:2];
               cnt_d   = rd_req_len;
               lat_d   = LAT_INIT;
               state_d = (RD_LATENCY == 0) ? S_RD_BURST : S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (lat_q == 4'd0) state_d = S_RD_BURST;
            else               lat_d   = lat_q - 4'd1;
         end
         S_RD_BURST: begin
            rd_rsp_valid_c = 1'b1;
            rd_rsp_data_c  = mem_q[ptr_q];
            rd_rsp_last_c  = (cnt_q == 8'd0);
            if (rd_rsp_ready) begin
               ptr_d = ptr_q + ADDR_W'(1);
               if (cnt_q == 8'd0) state_d = S_IDLE;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         S_WR_DATA: begin
            wr_data_ready_c = 1'b1;
            if (wr_data_valid) begin
               wr_hs = 1'b1;
               // The latched length wins; a disagreeing last marker only flags err.
               if (wr_data_last != (cnt_q == 8'd0)) err_d = 1'b1;
               ptr_d = ptr_q + ADDR_W'(1);
               if (cnt_q == 8'd0) state_d = S_IDLE;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Gating with rst makes every output drop the instant reset asserts.
   assign rd_req_ready  = rst & rd_req_ready_c;
   assign wr_req_ready  = rst & wr_req_ready_c;
   assign rd_rsp_valid  = rst & rd_rsp_valid_c;
   assign rd_rsp_last   = rst & rd_rsp_last_c;
   assign rd_rsp_data   = rst ? rd_rsp_data_c : 32'd0;
   assign wr_data_ready = rst & wr_data_ready_c;
   assign err           = err_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// tb/tb_mem_burst_responder.sv - self-checking bench for mem_burst_responder
module tb_mem_burst_responder;

   localparam int RD_LAT = 2;
   localparam int WORDS  = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_last, rd_rsp_ready;
   logic [31:0] rd_req_addr, rd_rsp_data;
   logic [7:0]  rd_req_len;
   logic        wr_req_valid, wr_req_ready, wr_data_valid, wr_data_last, wr_data_ready, err;
   logic [31:0] wr_req_addr, wr_data;
   logic [7:0]  wr_req_len;
   logic [3:0]  wr_data_strb;

   mem_burst_responder #(.ADDR_W(10), .RD_LATENCY(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
      .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
      .rd_rsp_last(rd_rsp_last), .rd_rsp_ready(rd_rsp_ready),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
      .wr_req_ready(wr_req_ready), .wr_data_valid(wr_data_valid), .wr_data(wr_data),
      .wr_data_strb(wr_data_strb), .wr_data_last(wr_data_last), .wr_data_ready(wr_data_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wr_addr;
      logic [31:0] rd_addr;
      logic [31:0] init;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } strb_vec_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model [0:WORDS-1];
   bit          err_exp = 1'b0;
   logic [31:0] wd [0:255];
   logic [3:0]  ws [0:255];
   logic [31:0] rq [0:255];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
      return (old & ~m) | (nw & m);
   endfunction

   function automatic int pick_hold(input int b, input int bp_beat, input bit rnd);
      if (b == bp_beat) return 3;
      if (rnd) return int'($urandom_range(0, 2));
      return 0;
   endfunction

   task automatic do_write(input logic [31:0] addr, input int len, input int last_beat,
                           input bit gaps, output int first_wait);
      int t;
      int w;
      wr_req_valid = 1'b1;
      wr_req_addr  = addr;
      wr_req_len   = 8'(len);
      t = 0;
      @(negedge clk);
      while (!wr_req_ready && t < 200) begin t++; @(negedge clk); end
      chk("wr_req_ready", 32'(wr_req_ready), 32'd1);
      @(posedge clk); #1;
      wr_req_valid = 1'b0;
      w = int'((addr >> 2) % WORDS);
      first_wait = 0;
      for (int b = 0; b <= len; b++) begin
         if (gaps) begin
            wr_data_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         wr_data_valid = 1'b1;
         wr_data       = wd[b];
         wr_data_strb  = ws[b];
         wr_data_last  = (b == last_beat);
         t = 0;
         @(negedge clk);
         while (!wr_data_ready && t < 200) begin t++; @(negedge clk); end
         if (b == 0) first_wait = t;
         chk("wr_data_ready", 32'(wr_data_ready), 32'd1);
         chk("req_ready_busy", 32'({rd_req_ready, wr_req_ready}), 32'd0);
         @(posedge clk); #1;
         model[w] = merge(model[w], wd[b], ws[b]);
         if ((b == last_beat) != (b == len)) err_exp = 1'b1;
         w = (w + 1) % WORDS;
      end
      wr_data_valid = 1'b0;
      wr_data_last  = 1'b0;
      chk("wr_done_ready", 32'(wr_data_ready), 32'd0);
      chk("err", 32'(err), 32'(err_exp));
   endtask

   task automatic do_read(input logic [31:0] addr, input int len, input int bp_beat,
                          input bit rnd_bp, output int lat, output int req_wait);
      int t, w, b, cyc, hold;
      bit seen, held;
      logic [31:0] prev_d;
      logic        prev_l;
      rd_req_valid = 1'b1;
      rd_req_addr  = addr;
      rd_req_len   = 8'(len);
      t = 0;
      @(negedge clk);
      while (!rd_req_ready && t < 200) begin t++; @(negedge clk); end
      req_wait = t;
      chk("rd_req_ready", 32'(rd_req_ready), 32'd1);
      @(posedge clk); #1;
      rd_req_valid = 1'b0;
      w = int'((addr >> 2) % WORDS);
      b = 0; cyc = 0; lat = 0; seen = 0; held = 0; prev_d = '0; prev_l = 1'b0;
      hold = pick_hold(0, bp_beat, rnd_bp);
      while (b <= len && cyc < 2000) begin
         rd_rsp_ready = (hold == 0);
         @(negedge clk);
         if (!rd_rsp_valid) begin
            if (seen) chk("rd_valid_in_burst", 32'(rd_rsp_valid), 32'd1);
            else lat++;
         end else begin
            seen = 1;
            chk("rd_data", rd_rsp_data, model[w]);
            chk("rd_last", 32'(rd_rsp_last), 32'(b == len));
            if (held) begin
               chk("rd_hold_data", rd_rsp_data, prev_d);
               chk("rd_hold_last", 32'(rd_rsp_last), 32'(prev_l));
            end
            if (hold == 0) begin
               rq[b] = rd_rsp_data;
               b++;
               w = (w + 1) % WORDS;
               held = 0;
               hold = pick_hold(b, bp_beat, rnd_bp);
            end else begin
               held = 1;
               prev_d = rd_rsp_data;
               prev_l = rd_rsp_last;
               hold--;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      rd_rsp_ready = 1'b0;
      chk("rd_beats", 32'(b), 32'(len + 1));
      chk("rd_latency", 32'(lat), 32'(RD_LAT));
      chk("rd_done_valid", 32'(rd_rsp_valid), 32'd0);
   endtask

   strb_vec_t tbl [7];

   initial begin
      int fw, lat, rw, t, beats;
      logic [31:0] a;
      int len;

      tbl[0] = '{32'h40, 32'h40, 32'hAABBCCDD, 32'h11223344, 4'b0100, 32'hAA22CCDD};
      tbl[1] = '{32'h44, 32'h44, 32'hAABBCCDD, 32'h11223344, 4'b0001, 32'hAABBCC44};
      tbl[2] = '{32'h48, 32'h48, 32'hAABBCCDD, 32'h11223344, 4'b1001, 32'h11BBCC44};
      tbl[3] = '{32'h4C, 32'h4C, 32'hAABBCCDD, 32'h11223344, 4'b0000, 32'hAABBCCDD};
      tbl[4] = '{32'h50, 32'h50, 32'h00000000, 32'hFFFFFFFF, 4'b0110, 32'h00FFFF00};
      tbl[5] = '{32'h57, 32'h54, 32'h12345678, 32'h9ABCDEF0, 4'b1111, 32'h9ABCDEF0};
      tbl[6] = '{32'hFFFFF058, 32'h58, 32'h00000000, 32'hCAFEBABE, 4'b1100, 32'hCAFE0000};

      rst = 1'b0;
      rd_req_valid = 0; rd_req_addr = '0; rd_req_len = '0; rd_rsp_ready = 0;
      wr_req_valid = 0; wr_req_addr = '0; wr_req_len = '0;
      wr_data_valid = 0; wr_data = '0; wr_data_strb = '0; wr_data_last = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", 32'({rd_req_ready, wr_req_ready, rd_rsp_valid, rd_rsp_last,
                             wr_data_ready, err}), 32'd0);
      chk("reset_data", rd_rsp_data, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'({rd_req_ready, wr_req_ready, rd_rsp_valid, wr_data_ready}), 32'b1100);
      @(posedge clk); #1;

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
         do_write(32'(k * 1024), 255, 255, 0, fw);
      end

      for (int v = 0; v < 7; v++) begin
         wd[0] = tbl[v].init; ws[0] = 4'hF;
         do_write(tbl[v].wr_addr, 0, 0, 0, fw);
         wd[0] = tbl[v].data; ws[0] = tbl[v].strb;
         do_write(tbl[v].wr_addr, 0, 0, 0, fw);
         chk("wr_first_ready", 32'(fw), 32'd0);
         do_read(tbl[v].rd_addr, 0, -1, 0, lat, rw);
         chk("strb_result", rq[0], tbl[v].exp);
      end

      for (int i = 0; i < 8; i++) begin wd[i] = 32'h11 * 32'(i + 1); ws[i] = 4'hF; end
      do_write(32'h100, 7, 7, 0, fw);
      do_read(32'h100, 7, -1, 0, lat, rw);
      for (int i = 0; i < 8; i++) chk("readback", rq[i], 32'h11 * 32'(i + 1));

      do_read(32'h300, 3, 2, 0, lat, rw);

      for (int i = 0; i < 4; i++) begin wd[i] = 32'hBEEF0000 + 32'(i); ws[i] = 4'hF; end
      rd_req_valid = 1'b1; rd_req_addr = 32'h600; rd_req_len = 8'd3;
      wr_req_valid = 1'b1; wr_req_addr = 32'h600; wr_req_len = 8'd3;
      #1;
      chk("simul_rd_ready", 32'(rd_req_ready), 32'd0);
      chk("simul_wr_ready", 32'(wr_req_ready), 32'd1);
      do_write(32'h600, 3, 3, 0, fw);
      chk("turnaround_rd_ready", 32'(rd_req_ready), 32'd1);
      do_read(32'h600, 3, -1, 0, lat, rw);
      chk("simul_rd_wait", 32'(rw), 32'd0);
      chk("simul_new_data", rq[3], 32'hBEEF0003);

      for (int n = 0; n < 80; n++) begin
         a = $urandom;
         len = int'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(a, len, len, 1, fw);
         end else begin
            do_read(a, len, -1, 1, lat, rw);
         end
      end

      for (int i = 0; i < 4; i++) begin wd[i] = 32'hE0E0_0000 + 32'(i); ws[i] = 4'hF; end
      do_write(32'(1022 * 4), 3, 1, 0, fw);
      chk("err_set", 32'(err), 32'd1);
      do_read(32'(1022 * 4), 3, -1, 0, lat, rw);
      for (int i = 0; i < 4; i++) chk("wrap_data", rq[i], 32'hE0E0_0000 + 32'(i));
      do_read(32'h0, 1, -1, 0, lat, rw);
      chk("wrap_word0", rq[0], 32'hE0E0_0002);
      chk("err_sticky", 32'(err), 32'd1);

      rd_req_valid = 1'b1; rd_req_addr = 32'h200; rd_req_len = 8'd5;
      @(negedge clk);
      chk("mid_rd_ready", 32'(rd_req_ready), 32'd1);
      @(posedge clk); #1;
      rd_req_valid = 1'b0;
      rd_rsp_ready = 1'b1;
      t = 0; beats = 0;
      while (beats < 2 && t < 50) begin
         @(negedge clk);
         if (rd_rsp_valid) beats++;
         @(posedge clk); #1;
         t++;
      end
      chk("pre_reset_beats", 32'(beats), 32'd2);
      chk("beat2_valid", 32'(rd_rsp_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_ctrl", 32'({rd_req_ready, wr_req_ready, rd_rsp_valid, rd_rsp_last,
                                 wr_data_ready, err}), 32'd0);
      chk("async_rst_data", rd_rsp_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      rd_rsp_ready = 1'b0;
      err_exp = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(rd_req_ready), 32'd1);
      chk("post_rst_err", 32'(err), 32'd0);
      chk("post_rst_valid", 32'(rd_rsp_valid), 32'd0);
      @(posedge clk); #1;
      do_read(32'h200, 5, -1, 0, lat, rw);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
